// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read-channel arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker; on a tie the requester that did not win last time goes.
module rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = REQ_I;
    if (req == 2'b11) gnt = ~last;
    else if (req[1])  gnt = REQ_D;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between the I-cache (requester 0) and D-cache (requester 1),
// one outstanding burst at a time, round-robin between simultaneous requests.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ADDR_W-1:0] req_araddr,
  input  logic [15:0]         req_arlen,
  input  logic [1:0]          req_arvalid,
  output logic [1:0]          req_arready,
  output logic [DATA_W-1:0]   req_rdata,
  output logic [1:0]          req_rvalid,
  output logic                req_rlast,
  input  logic [1:0]          req_rready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                err
);

  state_e            state, state_nxt;
  logic              gnt, last_gnt, arb_gnt;
  logic [ADDR_W-1:0] addr_r, sel_addr;
  logic [7:0]        len_r, sel_len, beat_cnt;
  logic              beat, err_set;

  rr_arb2 u_arb (
    .req  (req_arvalid),
    .last (last_gnt),
    .gnt  (arb_gnt)
  );

  assign sel_addr = arb_gnt ? req_araddr[2*ADDR_W-1:ADDR_W] : req_araddr[ADDR_W-1:0];
  assign sel_len  = arb_gnt ? req_arlen[15:8] : req_arlen[7:0];

  assign beat = m_rvalid & m_rready;

  // Beats are still forwarded on error; the FSM always follows m_rlast.
  assign err_set = (m_rvalid && state != ST_DATA) ||
                   (beat && ((m_rid != ID_W'(gnt)) || (m_rlast && beat_cnt != len_r)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= REQ_I;
      last_gnt <= REQ_D;
      addr_r   <= '0;
      len_r    <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set) err <= 1'b1;
      case (state)
        ST_IDLE: if (|req_arvalid) begin
          gnt      <= arb_gnt;
          addr_r   <= sel_addr;
          len_r    <= sel_len;
          beat_cnt <= '0;
        end
        ST_DATA: if (beat) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (m_rlast) last_gnt <= gnt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    m_arvalid   = 1'b0;
    req_arready = 2'b00;
    req_rvalid  = 2'b00;
    req_rlast   = 1'b0;
    m_rready    = 1'b0;
    case (state)
      ST_IDLE: if (|req_arvalid) state_nxt = ST_ADDR;
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          req_arready = onehot2(gnt);
          state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        m_rready   = gnt ? req_rready[1] : req_rready[0];
        req_rvalid = m_rvalid ? onehot2(gnt) : 2'b00;
        req_rlast  = m_rlast;
        if (m_rvalid && m_rready && m_rlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign m_araddr  = addr_r;
  assign m_arlen   = len_r;
  assign m_arid    = ID_W'(gnt);
  assign m_arsize  = SIZE_4B;
  assign m_arburst = BURST_INCR;
  assign req_rdata = m_rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] req_araddr;
  logic [15:0]   req_arlen;
  logic [1:0]    req_arvalid, req_arready, req_rvalid, req_rready;
  logic [DW-1:0] req_rdata;
  logic          req_rlast;
  logic [IW-1:0] m_arid, m_rid;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, err;
  logic [DW-1:0] m_rdata;

  int checks = 0;
  int passed = 0;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arvalid(req_arvalid),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rvalid(req_rvalid),
    .req_rlast(req_rlast), .req_rready(req_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] oh(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req_araddr  = '0;
    req_arlen   = '0;
    req_arvalid = 2'b00;
    req_rready  = 2'b00;
    m_arready   = 1'b0;
    m_rid       = '0;
    m_rdata     = '0;
    m_rlast     = 1'b0;
    m_rvalid    = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
    req_arvalid[i]        = 1'b1;
    req_araddr[i*AW +: AW] = a;
    req_arlen[i*8 +: 8]    = l;
  endtask

  task automatic beat(input logic id, input logic [DW-1:0] d, input logic last);
    m_rvalid = 1'b1;
    m_rid    = IW'(id);
    m_rdata  = d;
    m_rlast  = last;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if ({m_arvalid, m_rready, req_arready, req_rvalid, req_rlast} !== 7'b0)
      $display("FAIL reset_valids: got %b exp 0", {m_arvalid, m_rready, req_arready, req_rvalid, req_rlast}); else passed++;
    checks++; if ({m_araddr, m_arlen, m_arid} !== 44'h0)
      $display("FAIL reset_ar: got %h/%h/%h exp 0", m_araddr, m_arlen, m_arid); else passed++;
    checks++; if ({m_arsize, m_arburst, err} !== {3'b010, 2'b01, 1'b0})
      $display("FAIL reset_const: got %b/%b/%b exp 010/01/0", m_arsize, m_arburst, err); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    set_req(0, 32'h1FC0_0000, 8'd7);
    req_rready = 2'b11;
    #1;
    checks++; if (m_arvalid !== 1'b0) $display("FAIL single_idle_arvalid: got %b exp 0", m_arvalid); else passed++;
    tick();
    #1;
    checks++; if ({m_arvalid, m_arid, m_arlen} !== {1'b1, 4'd0, 8'd7})
      $display("FAIL single_ar: got %b/%h/%h exp 1/0/7", m_arvalid, m_arid, m_arlen); else passed++;
    checks++; if (m_araddr !== 32'h1FC0_0000) $display("FAIL single_araddr: got %h exp 1fc00000", m_araddr); else passed++;
    m_arready = 1'b1;
    #1;
    checks++; if (req_arready !== 2'b01) $display("FAIL single_arready: got %b exp 01", req_arready); else passed++;
    tick();
    req_arvalid = 2'b00;
    m_arready   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      beat(1'b0, DW'(32'hA0 + k), k == 7);
      #1;
      checks++; if ({req_rvalid, req_rlast} !== {2'b01, k == 7})
        $display("FAIL single_beat%0d: got rvalid %b rlast %b exp 01/%0d", k, req_rvalid, req_rlast, k == 7); else passed++;
      checks++; if (req_rdata !== DW'(32'hA0 + k))
        $display("FAIL single_data%0d: got %h exp %h", k, req_rdata, 32'hA0 + k); else passed++;
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    checks++; if ({err, m_arvalid, m_rready} !== 3'b000)
      $display("FAIL single_end: got err %b arvalid %b rready %b exp 000", err, m_arvalid, m_rready); else passed++;
  endtask

  task automatic test_both;
    do_reset();
    set_req(0, 32'h0000_1000, 8'd7);
    set_req(1, 32'hBFAF_8000, 8'd0);
    req_rready = 2'b11;
    tick();
    #1;
    checks++; if ({m_arid, m_araddr} !== {4'd0, 32'h0000_1000})
      $display("FAIL both_first: got id %h addr %h exp 0/1000", m_arid, m_araddr); else passed++;
    m_arready = 1'b1;
    #1;
    checks++; if (req_arready !== 2'b01) $display("FAIL both_arready0: got %b exp 01", req_arready); else passed++;
    tick();
    req_arvalid[0] = 1'b0;
    m_arready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      beat(1'b0, DW'(k), k == 7);
      #1;
      checks++; if (req_rvalid !== 2'b01) $display("FAIL both_rvalid%0d: got %b exp 01", k, req_rvalid); else passed++;
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    checks++; if (m_arvalid !== 1'b0) $display("FAIL both_bubble: got %b exp 0", m_arvalid); else passed++;
    tick();
    #1;
    checks++; if ({m_arvalid, m_arid, m_araddr, m_arlen} !== {1'b1, 4'd1, 32'hBFAF_8000, 8'd0})
      $display("FAIL both_second: got %b/%h/%h/%h exp 1/1/bfaf8000/0", m_arvalid, m_arid, m_araddr, m_arlen); else passed++;
    m_arready = 1'b1;
    #1;
    checks++; if (req_arready !== 2'b10) $display("FAIL both_arready1: got %b exp 10", req_arready); else passed++;
    tick();
    req_arvalid = 2'b00;
    m_arready   = 1'b0;
    beat(1'b1, 32'h55, 1'b1);
    #1;
    checks++; if ({req_rvalid, req_rlast, req_rdata} !== {2'b10, 1'b1, 32'h55})
      $display("FAIL both_beat1: got %b/%b/%h exp 10/1/55", req_rvalid, req_rlast, req_rdata); else passed++;
    tick();
    m_rvalid = 1'b0;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL both_err: got %b exp 0", err); else passed++;
  endtask

  task automatic test_rr;
    logic exp_g;
    do_reset();
    set_req(0, 32'h100, 8'd0);
    set_req(1, 32'h200, 8'd0);
    req_rready = 2'b11;
    exp_g = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      #1;
      checks++; if ({m_arvalid, m_arid} !== {1'b1, IW'(exp_g)})
        $display("FAIL rr_grant%0d: got %b/%h exp 1/%h", t, m_arvalid, m_arid, exp_g); else passed++;
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      beat(exp_g, DW'(t), 1'b1);
      #1;
      checks++; if (req_rvalid !== oh(exp_g)) $display("FAIL rr_rvalid%0d: got %b exp %b", t, req_rvalid, oh(exp_g)); else passed++;
      tick();
      m_rvalid = 1'b0;
      exp_g = ~exp_g;
    end
    req_arvalid = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_stall;
    int pulses;
    do_reset();
    set_req(1, 32'h2000_0040, 8'd0);
    req_rready = 2'b11;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({m_arvalid, m_araddr, req_arready} !== {1'b1, 32'h2000_0040, 2'b00})
        $display("FAIL stall_c%0d: got %b/%h/%b exp 1/20000040/00", c, m_arvalid, m_araddr, req_arready); else passed++;
      tick();
    end
    pulses = 0;
    m_arready = 1'b1;
    #1;
    if (req_arready != 2'b00) pulses++;
    tick();
    m_arready   = 1'b0;
    req_arvalid = 2'b00;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (req_arready != 2'b00) pulses++;
      checks++; if (m_arvalid !== 1'b0) $display("FAIL stall_after%0d: got %b exp 0", c, m_arvalid); else passed++;
      tick();
    end
    checks++; if (pulses !== 1) $display("FAIL stall_pulses: got %0d exp 1", pulses); else passed++;
    beat(1'b1, 32'h0, 1'b1);
    tick();
    m_rvalid = 1'b0;
  endtask

  task automatic test_rready;
    int idx, got, stalls, cyc;
    do_reset();
    set_req(0, 32'h3000, 8'd7);
    tick();
    m_arready = 1'b1;
    tick();
    m_arready   = 1'b0;
    req_arvalid = 2'b00;
    idx = 0; got = 0; stalls = 0; cyc = 0;
    while (idx <= 7 && cyc < 40) begin
      beat(1'b0, DW'(32'hC0 + idx), idx == 7);
      req_rready = {1'b0, !(cyc >= 3 && cyc < 6)};
      #1;
      checks++; if (m_rready !== req_rready[0])
        $display("FAIL rready_c%0d: got %b exp %b", cyc, m_rready, req_rready[0]); else passed++;
      if (!m_rready) stalls++;
      if (req_rvalid[0] && req_rready[0]) begin
        checks++; if (req_rdata !== DW'(32'hC0 + got))
          $display("FAIL rready_data%0d: got %h exp %h", got, req_rdata, 32'hC0 + got); else passed++;
        got++;
      end
      tick();
      if (req_rready[0]) idx++;
      cyc++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    checks++; if ({got, stalls} !== {32'd8, 32'd3}) $display("FAIL rready_count: got %0d beats %0d stalls exp 8/3", got, stalls); else passed++;
    checks++; if (m_rready !== 1'b0) $display("FAIL rready_idle: got %b exp 0", m_rready); else passed++;
  endtask

  task automatic test_err;
    do_reset();
    set_req(0, 32'h4000, 8'd7);
    req_rready = 2'b11;
    tick();
    m_arready = 1'b1;
    tick();
    m_arready   = 1'b0;
    req_arvalid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      beat(1'b0, DW'(k), k == 3);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    checks++; if ({err, m_rready, m_arvalid} !== 3'b100)
      $display("FAIL err_early: got err %b rready %b arvalid %b exp 100", err, m_rready, m_arvalid); else passed++;
    set_req(1, 32'h5000, 8'd0);
    tick();
    #1;
    checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd1})
      $display("FAIL err_regrant: got %b/%h exp 1/1", m_arvalid, m_arid); else passed++;
    m_arready = 1'b1;
    tick();
    m_arready   = 1'b0;
    req_arvalid = 2'b00;
    beat(1'b1, 32'h0, 1'b1);
    tick();
    m_rvalid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else passed++;
    // wrong id on a well-formed single-beat burst
    do_reset();
    set_req(0, 32'h6000, 8'd0);
    req_rready = 2'b11;
    tick();
    m_arready = 1'b1;
    tick();
    m_arready   = 1'b0;
    req_arvalid = 2'b00;
    beat(1'b1, 32'h77, 1'b1);
    #1;
    checks++; if ({req_rvalid, req_rdata} !== {2'b01, 32'h77})
      $display("FAIL err_rid_fwd: got %b/%h exp 01/77", req_rvalid, req_rdata); else passed++;
    tick();
    m_rvalid = 1'b0;
    #1;
    checks++; if (err !== 1'b1) $display("FAIL err_rid: got %b exp 1", err); else passed++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_req(1, 32'h7000_0000, 8'd7);
    req_rready = 2'b11;
    tick();
    m_arready = 1'b1;
    tick();
    m_arready   = 1'b0;
    req_arvalid = 2'b00;
    for (int k = 0; k < 2; k++) begin
      beat(1'b1, DW'(k), 1'b0);
      tick();
    end
    rst = 1'b1;
    m_rvalid = 1'b0;
    tick();
    checks++; if ({m_arvalid, m_rready, req_arready, req_rvalid, req_rlast, err} !== 8'b0)
      $display("FAIL rstmid_valids: got %b exp 0", {m_arvalid, m_rready, req_arready, req_rvalid, req_rlast, err}); else passed++;
    checks++; if ({m_araddr, m_arlen, m_arid} !== 44'h0)
      $display("FAIL rstmid_ar: got %h/%h/%h exp 0", m_araddr, m_arlen, m_arid); else passed++;
    rst = 1'b0;
  endtask

  // Transaction-level model: when the channel is free and someone is pending, pick the winner;
  // a burst occupies the channel until its last beat is handed over.
  task automatic test_random;
    logic [1:0]    pend;
    logic [AW-1:0] pa [2];
    logic [7:0]    pl [2];
    logic [AW-1:0] eaddr;
    logic [7:0]    elen;
    logic          win, lastg;
    logic [1:0]    e_arr, e_rv;
    logic          e_rr;
    int            ph, idx, errs_before;
    do_reset();
    pend = 2'b00; pa[0] = '0; pa[1] = '0; pl[0] = '0; pl[1] = '0;
    eaddr = '0; elen = '0; win = 1'b0; lastg = 1'b1; ph = 0; idx = 0;
    errs_before = checks - passed;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && c < 2800 && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = AW'($urandom) & ~AW'(3);
          pl[i]   = ($urandom_range(1) == 1) ? 8'd7 : 8'd0;
        end
      req_arvalid = pend;
      req_araddr  = {pa[1], pa[0]};
      req_arlen   = {pl[1], pl[0]};
      req_rready  = 2'($urandom);
      m_arready   = 1'($urandom);
      m_rvalid    = (ph == 2) && ($urandom_range(2) != 0);
      m_rid       = IW'(win);
      m_rdata     = eaddr ^ DW'(idx);
      m_rlast     = (ph == 2) && (idx == int'(elen));
      #1;
      e_arr = (ph == 1 && m_arready) ? oh(win) : 2'b00;
      e_rv  = (ph == 2 && m_rvalid) ? oh(win) : 2'b00;
      e_rr  = (ph == 2) ? req_rready[win] : 1'b0;
      checks++; if (m_arvalid !== (ph == 1)) $display("FAIL rnd_arvalid c%0d: got %b exp %0d", c, m_arvalid, ph == 1); else passed++;
      checks++; if (req_arready !== e_arr) $display("FAIL rnd_arready c%0d: got %b exp %b", c, req_arready, e_arr); else passed++;
      checks++; if (req_rvalid !== e_rv) $display("FAIL rnd_rvalid c%0d: got %b exp %b", c, req_rvalid, e_rv); else passed++;
      checks++; if (m_rready !== e_rr) $display("FAIL rnd_rready c%0d: got %b exp %b", c, m_rready, e_rr); else passed++;
      if (ph == 1) begin
        checks++; if ({m_araddr, m_arlen, m_arid} !== {eaddr, elen, IW'(win)})
          $display("FAIL rnd_ar c%0d: got %h/%h/%h exp %h/%h/%h", c, m_araddr, m_arlen, m_arid, eaddr, elen, win); else passed++;
      end
      if (ph == 2 && m_rvalid) begin
        checks++; if ({req_rdata, req_rlast} !== {eaddr ^ DW'(idx), idx == int'(elen)})
          $display("FAIL rnd_beat c%0d: got %h/%b exp %h/%0d", c, req_rdata, req_rlast, eaddr ^ DW'(idx), idx == int'(elen)); else passed++;
      end
      checks++; if (err !== 1'b0) $display("FAIL rnd_err c%0d: got %b exp 0", c, err); else passed++;
      case (ph)
        0: if (pend != 2'b00) begin
          win   = (pend == 2'b11) ? ~lastg : pend[1];
          eaddr = pa[win];
          elen  = pl[win];
          ph    = 1;
        end
        1: if (m_arready) begin
          pend[win] = 1'b0;
          ph  = 2;
          idx = 0;
        end
        default: if (m_rvalid && req_rready[win]) begin
          if (idx == int'(elen)) begin
            ph    = 0;
            lastg = win;
          end else idx++;
        end
      endcase
      tick();
      if (checks - passed > errs_before + 20) begin
        $display("FAIL rnd_abort: too many mismatches at cycle %0d", c);
        break;
      end
    end
    idle_inputs();
    checks++; if ({ph, pend} !== {32'd0, 2'b00}) $display("FAIL rnd_drain: got phase %0d pending %b exp 0/00", ph, pend); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_both();
    test_rr();
    test_stall();
    test_rready();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Shares the core's single AXI read channel (AR/R) between the instruction cache (requester 0) and the data cache (requester 1).
- Round-robin arbitration; one outstanding transaction at a time.
- Each requester sees a plain AR/R handshake identical to the one it drives today.
- Sits between the two caches' master ports and the top-level AXI read interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (one word per beat)
ID_W, 4, AXI ID width; requester n issues arid = n

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_araddr  in  2*ADDR_W  per-requester address, [ADDR_W-1:0] = requester 0
req_arlen  in  2*8  per-requester burst length-1 (cached line = 7, uncached = 0)
req_arvalid  in  2  per-requester address valid
req_arready  out  2  per-requester address accepted (one-hot pulse)
req_rdata  out  DATA_W  read data, shared by both requesters
req_rvalid  out  2  per-requester beat valid (one-hot)
req_rlast  out  1  last beat, qualified by req_rvalid
req_rready  in  2  per-requester beat ready
m_arid  out  ID_W  AXI AR id
m_araddr  out  ADDR_W  AXI AR address
m_arlen  out  8  AXI AR length
m_arsize  out  3  constant 3'b010
m_arburst  out  2  constant 2'b01 (INCR)
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_rid  in  ID_W  AXI R id
m_rdata  in  DATA_W  AXI R data
m_rlast  in  1  AXI R last
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready
err  out  1  sticky protocol error

Behaviour:
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- Registers: gnt (1 bit), last_gnt (1 bit), addr_r, len_r, beat_cnt (8 bits), err.
- Reset values: state IDLE, last_gnt=1 (so requester 0 wins the first tie), beat_cnt=0, err=0.
- Output values after reset: m_arvalid=0, m_rready=0, req_arready=0, req_rvalid=0, req_rlast=0, m_araddr=0, m_arlen=0, m_arid=0.
- IDLE:
  - If any req_arvalid is set, the winner is chosen as follows: single requester wins; on both, the requester != last_gnt wins.
  - Latch gnt, addr_r, len_r; clear beat_cnt; go to ADDR.
  - No output is asserted in IDLE.
- ADDR:
  - m_arvalid=1, with m_araddr/m_arlen/m_arid driven from the registers.
  - On m_arready: req_arready[gnt]=1 in the same cycle, then go to DATA.
  - Minimum AR latency is 1 cycle from request to m_arvalid.
- DATA:
  - req_rdata=m_rdata, req_rvalid[gnt]=m_rvalid, req_rlast=m_rlast, m_rready=req_rready[gnt].
  - The non-granted requester sees rvalid=0.
  - On each beat (m_rvalid & m_rready), beat_cnt increments.
  - On a beat with m_rlast: last_gnt<=gnt, go to IDLE.
  - The next grant can occur in the IDLE cycle that follows (one bubble between transactions).
- Error detection: err is set (sticky until rst) when either of these happens:
  - m_rlast arrives with beat_cnt != len_r;
  - a beat arrives with m_rid != gnt.
  - In both cases the beat is still forwarded and the FSM still follows m_rlast.
- Request lifetime: a requester dropping arvalid while in IDLE is simply not granted. Once latched, the request cannot be cancelled; a cache flush must still drain the burst.
- A requester keeps arvalid high until it sees req_arready. The loser's arvalid stays pending and it wins next by round-robin.
- Reset mid-transaction returns the block to IDLE and drops all valids. The AXI slave shares rst, so no orphaned beats are expected.
- m_rvalid in IDLE/ADDR: ignored (m_rready=0) and err is set.

Decomposition:
- Shared package: state encodings, AXI constants (SIZE_4B=3'b010, BURST_INCR=2'b01), requester IDs (REQ_I=0, REQ_D=1).
- One natural sub-module: rr_arb2. It is a combinational 2-way round-robin picker: inputs req[1:0] and last; output gnt.

Test Plan:
- Only requester 0 requests araddr=0x1FC0_0000, arlen=7:
  - m_arvalid rises 1 cycle later with m_arid=0, m_arlen=7.
  - Slave returns 8 beats 0xA0..0xA7; requester 0 sees rvalid on all 8, rlast on the 8th.
  - err=0.
- Both requesters assert in the same cycle after reset:
  - Requester 0 is granted first.
  - Requester 1 (arlen=0, addr 0xBFAF_8000) is granted in the IDLE cycle after requester 0's rlast, with m_arid=1.
- Both requesters assert continuously for 4 transactions -> grant sequence is 0, 1, 0, 1.
- m_arready held low for 5 cycles -> m_arvalid and m_araddr stay stable; req_arready pulses exactly once.
- Requester 0 holds rready=0 for 3 cycles mid-burst -> m_rready=0 for those cycles; no beat is lost or duplicated.
- Error cases:
  - Slave asserts m_rlast on beat 4 of arlen=7 -> err=1 and the FSM returns to IDLE.
  - Asserting rst mid-DATA -> all outputs return to their reset values in the next cycle.
